// File: rtl/g15_pkg.sv
// Shared types and constants for the G-15 control gate power-up logic.
// Holds the sequencer state encoding and the per-state output decode.
package g15_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    CLEAR   = 3'd2,
    NT_COPY = 3'd3,
    NO_OP   = 3'd4,
    OP      = 3'd5,
    ATS     = 3'd6,
    RUN     = 3'd7
  } pwr_state_t;

  localparam int DRUM_BITS_PER_REV = 3132;

  typedef struct packed {
    logic clear;
    logic nt;
    logic no_op;
    logic op;
    logic ats;
    logic run;
  } pwr_out_t;

  // A revolution count of zero would never terminate, so it behaves as one.
  function automatic int unsigned eff_revs(input int unsigned n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

  function automatic pwr_out_t decode_outputs(input pwr_state_t s);
    pwr_out_t o;
    o = '{clear: 1'b0, nt: 1'b0, no_op: 1'b0, op: 1'b0, ats: 1'b0, run: 1'b0};
    case (s)
      IDLE, WARMUP, CLEAR: o.clear = 1'b1;
      NT_COPY:             o.nt    = 1'b1;
      NO_OP:               o.no_op = 1'b1;
      OP:                  o.op    = 1'b1;
      ATS:                 o.ats   = 1'b1;
      RUN:                 o.run   = 1'b1;
      default:             o.clear = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/power_sequencer_rev_counter.sv
// Drum revolution counter: loads a revolution budget, counts down on each T0,
// and flags the T0 that completes the budget.
module rev_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         t0,
  output logic         term
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = W'(0);

  logic [W-1:0] count;

  // Load wins over decrement; an empty counter stays empty so idle T0s are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= ZERO;
    end else if (load) begin
      count <= load_val;
    end else if (t0 && (count != ZERO)) begin
      count <= count - ONE;
    end else begin
      count <= count;
    end
  end

  assign term = t0 && (count == ONE);

endmodule

// File: rtl/power_sequencer.sv
// Power-up sequencer for the G-15 control gate: steps clear, number-track copy,
// no-op, op and auto tape start, aligned to drum revolutions.
module power_sequencer
  import g15_pkg::*;
#(
  parameter int unsigned WARMUP_REVS      = 4,
  parameter int unsigned CLEAR_REVS       = 2,
  parameter int unsigned NO_OP_REVS       = 2,
  parameter int unsigned ATS_TIMEOUT_REVS = 64
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T0,
  input  logic       SW_POWER,
  input  logic       SW_NT_COPY,
  input  logic       SW_ATS,
  input  logic       ATS_DONE,
  output logic       PWR_CLEAR,
  output logic       PWR_NO_CLEAR,
  output logic       PWR_NT,
  output logic       PWR_NO_OP,
  output logic       PWR_OP,
  output logic       PWR_ATS,
  output logic       PWR_RUN,
  output pwr_state_t PWR_STATE
);

  localparam int unsigned WARM_N = eff_revs(WARMUP_REVS);
  localparam int unsigned CLR_N  = eff_revs(CLEAR_REVS);
  localparam int unsigned NOOP_N = eff_revs(NO_OP_REVS);
  localparam int unsigned ATS_N  = eff_revs(ATS_TIMEOUT_REVS);
  localparam int unsigned MAX_A  = (WARM_N > CLR_N) ? WARM_N : CLR_N;
  localparam int unsigned MAX_B  = (NOOP_N > ATS_N) ? NOOP_N : ATS_N;
  localparam int unsigned MAX_N  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int RC_W = $clog2(MAX_N) + 1;

  pwr_state_t      state;
  pwr_state_t      next_state;
  logic            load;
  logic [RC_W-1:0] load_val;
  logic            term;
  pwr_out_t        next_out;

  rev_counter #(.W(RC_W)) u_rev_counter (
    .clk      (CLOCK),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .t0       (T0),
    .term     (term)
  );

  // Next-state logic; losing DC power overrides every other transition.
  always_comb begin
    next_state = state;
    if ((state != IDLE) && !SW_POWER) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (SW_POWER) next_state = WARMUP;  else next_state = IDLE;
        WARMUP:  if (term)     next_state = CLEAR;   else next_state = WARMUP;
        CLEAR:   if (term)     next_state = SW_NT_COPY ? NT_COPY : NO_OP;
                 else          next_state = CLEAR;
        NT_COPY: if (term)     next_state = NO_OP;   else next_state = NT_COPY;
        NO_OP:   if (term)     next_state = OP;      else next_state = NO_OP;
        OP:      if (term)     next_state = SW_ATS ? ATS : RUN;
                 else          next_state = OP;
        ATS:     if (ATS_DONE || term) next_state = RUN; else next_state = ATS;
        RUN:     next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // Each state entry reloads the counter with that state's revolution budget.
  always_comb begin
    load     = (next_state != state);
    load_val = {RC_W{1'b0}};
    case (next_state)
      WARMUP:      load_val = RC_W'(WARM_N);
      CLEAR:       load_val = RC_W'(CLR_N);
      NT_COPY, OP: load_val = RC_W'(1);
      NO_OP:       load_val = RC_W'(NOOP_N);
      ATS:         load_val = RC_W'(ATS_N);
      default:     load_val = {RC_W{1'b0}};
    endcase
  end

  assign next_out = decode_outputs(next_state);

  // State register with outputs decoded from the next state so they switch on the same edge.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      PWR_CLEAR    <= 1'b1;
      PWR_NO_CLEAR <= 1'b0;
      PWR_NT       <= 1'b0;
      PWR_NO_OP    <= 1'b0;
      PWR_OP       <= 1'b0;
      PWR_ATS      <= 1'b0;
      PWR_RUN      <= 1'b0;
    end else begin
      state        <= next_state;
      PWR_CLEAR    <= next_out.clear;
      PWR_NO_CLEAR <= ~next_out.clear;
      PWR_NT       <= next_out.nt;
      PWR_NO_OP    <= next_out.no_op;
      PWR_OP       <= next_out.op;
      PWR_ATS      <= next_out.ats;
      PWR_RUN      <= next_out.run;
    end
  end

  assign PWR_STATE = state;

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer: directed phase-length scenarios plus
// randomized T0 spacing and switch activity against a phase/revolution model.
module tb_power_sequencer;

  localparam int WARM = 4, CLR = 2, NOOP = 2, ATS_TO = 64;

  logic CLOCK = 1'b0, rst = 1'b1, T0 = 1'b0;
  logic SW_POWER = 1'b0, SW_NT_COPY = 1'b0, SW_ATS = 1'b0, ATS_DONE = 1'b0;
  logic PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_NO_OP, PWR_OP, PWR_ATS, PWR_RUN;
  logic [2:0] PWR_STATE;

  int total = 0, bad = 0;
  int cyc = 0, t0_left = 100;
  bit rand_mode = 1'b0;
  int m_phase = 0, m_t0s = 0;
  int last_state = 0, span_t0 = 0;
  int clear_t0 = 0, noop_cyc = 0, op_cyc = 0, nt_cyc = 0, ats_t0 = 0, warm_t0 = 0;

  power_sequencer #(
    .WARMUP_REVS(WARM), .CLEAR_REVS(CLR), .NO_OP_REVS(NOOP), .ATS_TIMEOUT_REVS(ATS_TO)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .SW_POWER(SW_POWER), .SW_NT_COPY(SW_NT_COPY),
    .SW_ATS(SW_ATS), .ATS_DONE(ATS_DONE), .PWR_CLEAR(PWR_CLEAR), .PWR_NO_CLEAR(PWR_NO_CLEAR),
    .PWR_NT(PWR_NT), .PWR_NO_OP(PWR_NO_OP), .PWR_OP(PWR_OP), .PWR_ATS(PWR_ATS),
    .PWR_RUN(PWR_RUN), .PWR_STATE(PWR_STATE)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic int clamp1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Revolutions each timed phase lasts (1..6 = warmup, clear, nt, no-op, op, ats).
  function automatic int need(input int ph);
    case (ph)
      1: return clamp1(WARM);
      2: return clamp1(CLR);
      4: return clamp1(NOOP);
      6: return clamp1(ATS_TO);
      default: return 1;
    endcase
  endfunction

  function automatic int succ(input int ph);
    case (ph)
      1: return 2;
      2: return SW_NT_COPY ? 3 : 4;
      3: return 4;
      4: return 5;
      5: return SW_ATS ? 6 : 7;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus number of T0s seen in it.
  initial forever begin
    @(posedge CLOCK or posedge rst);
    if (rst) begin
      m_phase = 0; m_t0s = 0;
    end else if (m_phase != 0 && !SW_POWER) begin
      m_phase = 0; m_t0s = 0;
    end else if (m_phase == 0) begin
      if (SW_POWER) begin m_phase = 1; m_t0s = 0; end
    end else if (m_phase == 6 && ATS_DONE) begin
      m_phase = 7; m_t0s = 0;
    end else if (m_phase != 7 && T0) begin
      if (m_t0s + 1 >= need(m_phase)) begin
        m_phase = succ(m_phase); m_t0s = 0;
      end else begin
        m_t0s = m_t0s + 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus phase-length measurements.
  initial forever begin
    logic [9:0] exp_v;
    logic clr;
    @(negedge CLOCK);
    clr = (m_phase <= 2);
    exp_v = {m_phase[2:0], clr, ~clr, m_phase == 3, m_phase == 4, m_phase == 5,
             m_phase == 6, m_phase == 7};
    check("outputs", {PWR_STATE, PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_NO_OP, PWR_OP,
                      PWR_ATS, PWR_RUN}, exp_v);
    if (int'(PWR_STATE) != last_state) begin
      if (PWR_STATE != 3'd0 && last_state >= 1 && last_state <= 5)
        check("phase_span", span_t0, need(last_state));
      span_t0 = 0;
    end
    last_state = int'(PWR_STATE);
    if (T0) span_t0++;
    if (T0 && PWR_CLEAR && SW_POWER) clear_t0++;
    if (PWR_NO_OP) noop_cyc++;
    if (PWR_OP) op_cyc++;
    if (PWR_NT) nt_cyc++;
    if (T0 && PWR_ATS) ats_t0++;
    if (T0 && PWR_STATE == 3'd1) warm_t0++;
  end

  task automatic step();
    @(posedge CLOCK); #1;
    cyc++;
    if (t0_left <= 1) begin
      T0 = 1'b1;
      t0_left = rand_mode ? int'($urandom_range(2, 9)) : 100;
    end else begin
      T0 = 1'b0;
      t0_left--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; SW_POWER = 1'b0; SW_NT_COPY = 1'b0; SW_ATS = 1'b0; ATS_DONE = 1'b0;
    rand_mode = 1'b0;
    step(); step();
    rst = 1'b0; T0 = 1'b0; cyc = 0; t0_left = 100;
    clear_t0 = 0; noop_cyc = 0; op_cyc = 0; nt_cyc = 0; ats_t0 = 0; warm_t0 = 0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      step();
      if (cyc == 50) SW_POWER = 1'b1;
    end
  endtask

  initial begin
    bit found;

    // Defaults, no NT copy, no ATS.
    do_reset();
    check("reset_state", PWR_STATE, 3'd0);
    check("reset_clear", PWR_CLEAR, 1'b1);
    check("reset_no_clear", PWR_NO_CLEAR, 1'b0);
    check("reset_run", PWR_RUN, 1'b0);
    run_to(1000);
    check("clear_t0s", clear_t0, 6);
    check("no_op_clocks", noop_cyc, 200);
    check("op_clocks", op_cyc, 100);
    check("run_high", PWR_RUN, 1'b1);
    check("run_state", PWR_STATE, 3'd7);

    // Number-track copy inserted between CLEAR and NO_OP.
    do_reset();
    SW_NT_COPY = 1'b1;
    run_to(1100);
    check("nt_clocks", nt_cyc, 100);
    check("nt_no_op_clocks", noop_cyc, 200);
    check("nt_run_state", PWR_STATE, 3'd7);

    // ATS finished early by ATS_DONE.
    do_reset();
    SW_ATS = 1'b1;
    for (int i = 0; i < 2000 && m_phase != 6; i++) begin
      step();
      if (cyc == 50) SW_POWER = 1'b1;
    end
    check("reach_ats", PWR_STATE, 3'd6);
    for (int i = 0; i < 30; i++) step();
    ATS_DONE = 1'b1;
    step();
    ATS_DONE = 1'b0;
    check("ats_done_run", PWR_RUN, 1'b1);
    check("ats_done_ats", PWR_ATS, 1'b0);
    check("ats_done_state", PWR_STATE, 3'd7);

    // ATS timeout.
    do_reset();
    SW_ATS = 1'b1;
    run_to(7700);
    check("ats_timeout_t0s", ats_t0, 64);
    check("ats_timeout_run", PWR_STATE, 3'd7);

    // Power removed mid-NO_OP together with T0, then restored.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (cyc == 50) SW_POWER = 1'b1;
      if (m_phase == 4 && T0) begin SW_POWER = 1'b0; found = 1'b1; end
    end
    step();
    check("drop_state", PWR_STATE, 3'd0);
    check("drop_clear", PWR_CLEAR, 1'b1);
    check("drop_no_op", PWR_NO_OP, 1'b0);
    warm_t0 = 0;
    SW_POWER = 1'b1;
    step();
    check("restart_state", PWR_STATE, 3'd1);
    for (int i = 0; i < 1000 && m_phase != 2; i++) step();
    check("restart_warm_t0s", warm_t0, 4);

    // Asynchronous reset while running.
    do_reset();
    run_to(1000);
    #2 rst = 1'b1;
    #1;
    check("async_state", PWR_STATE, 3'd0);
    check("async_clear", PWR_CLEAR, 1'b1);
    check("async_no_clear", PWR_NO_CLEAR, 1'b0);
    check("async_run", PWR_RUN, 1'b0);
    SW_POWER = 1'b0;
    step();
    rst = 1'b0;
    step(); step();
    check("post_reset_idle", PWR_STATE, 3'd0);
    SW_POWER = 1'b1;
    step();
    check("post_reset_warmup", PWR_STATE, 3'd1);

    // Randomized T0 spacing and switch activity.
    do_reset();
    rand_mode = 1'b1;
    t0_left = 3;
    SW_POWER = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (SW_POWER) SW_POWER = ($urandom_range(0, 499) != 0);
      else          SW_POWER = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) SW_NT_COPY = ~SW_NT_COPY;
      if ($urandom_range(0, 3) == 0) SW_ATS = ~SW_ATS;
      ATS_DONE = ($urandom_range(0, 39) == 0);
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
# power_sequencer

Power-up sequencer for the G-15 control gate. After DC power is applied it steps the number-track and command-control logic through a fixed sequence, aligned to drum revolutions: clear, optional number-track copy, no-op (number-track write), op, then auto tape start. It drives the PWR_* inputs of the control gate. It counts revolutions from the once-per-revolution origin pulse T0, and it returns the machine to the cleared state whenever power is removed.

## Interface
- WARMUP_REVS, 4: revolutions to wait after SW_POWER rises before clearing
- CLEAR_REVS, 2: full revolutions spent in CLEAR
- NO_OP_REVS, 2: full revolutions spent in NO_OP
- ATS_TIMEOUT_REVS, 64: revolutions to wait for ATS_DONE before giving up
- CLOCK  in  1  bit-time clock; one cycle per drum bit
- rst  in  1  asynchronous, active-high reset
- T0  in  1  one-cycle origin pulse, once per drum revolution
- SW_POWER  in  1  DC power switch; level
- SW_NT_COPY  in  1  maintenance: copy line 19 into the number track during power-up
- SW_ATS  in  1  auto tape start enabled; level
- ATS_DONE  in  1  tape controller has finished the auto-tape-start load; level
- PWR_CLEAR  out  1  clear the command flip-flops
- PWR_NO_CLEAR  out  1  number-track recirculation enabled; always ~PWR_CLEAR
- PWR_NT  out  1  copy M19 into the number track
- PWR_NO_OP  out  1  number-track initialization phase
- PWR_OP  out  1  leave initialization; reset CY and CG
- PWR_ATS  out  1  auto tape start request
- PWR_RUN  out  1  sequence complete, machine operable
- PWR_STATE  out  3  current state (pwr_state_t), for the maintenance panel

## Operation
- States: IDLE, WARMUP, CLEAR, NT_COPY, NO_OP, OP, ATS, RUN.
- Outputs are registered and are a pure function of the state:
  - IDLE, WARMUP, CLEAR: PWR_CLEAR=1.
  - NT_COPY: PWR_NT=1.
  - NO_OP: PWR_NO_OP=1.
  - OP: PWR_OP=1.
  - ATS: PWR_ATS=1.
  - RUN: PWR_RUN=1.
  - Every other output is 0 in each state. PWR_NO_CLEAR = ~PWR_CLEAR at all times.
- Revolution counter rc, width $clog2 of the largest parameter plus 1:
  - Loaded with the state's parameter on entry.
  - Decremented on each T0.
  - A timed state exits on the T0 where rc==1.
- Transitions:
  - IDLE→WARMUP: the clock where SW_POWER=1.
  - WARMUP→CLEAR: the WARMUP_REVS-th T0 after entry. The partial first revolution counts.
  - CLEAR→NT_COPY when SW_NT_COPY=1, otherwise CLEAR→NO_OP. Taken at the CLEAR_REVS-th T0; CLEAR is always entered on a T0, so the revolutions are whole.
  - NT_COPY→NO_OP: the next T0, giving exactly one revolution.
  - NO_OP→OP: the NO_OP_REVS-th T0.
  - OP→ATS when SW_ATS=1, otherwise OP→RUN. Taken at the next T0, giving one revolution of PWR_OP.
  - ATS→RUN: the first clock where ATS_DONE=1, or the ATS_TIMEOUT_REVS-th T0, whichever comes first.
  - RUN: holds while SW_POWER=1.
- SW_POWER=0 in any non-IDLE state → IDLE on the next clock. This has priority over every other transition.
- SW_NT_COPY and SW_ATS are sampled only at the transition that consumes them.
- T0 in IDLE is ignored.
- ATS_DONE outside the ATS state is ignored.
- A parameter value of 0 is treated as 1.

## Timing
- Reset (async): state=IDLE, rc=0. PWR_CLEAR=1, PWR_NO_CLEAR=0; all other outputs 0; PWR_STATE=IDLE.
- Output latency: outputs change on the clock edge after the qualifying input: T0, SW_POWER or ATS_DONE sampled high (or SW_POWER sampled low for power-off).
- Simultaneous events:
  - SW_POWER=0 together with T0 or ATS_DONE → IDLE.
  - ATS_DONE together with the timeout T0 → RUN. Both lead to the same state.
- Outputs never overlap between phases. Exactly one of PWR_NT, PWR_NO_OP, PWR_OP, PWR_ATS, PWR_RUN is high outside the clearing states.
- Back-to-back T0 pulses (any period ≥2 clocks) are legal. Benches may shorten the revolution from 3132 clocks.

## Structure
- g15_pkg holds:
  - typedef enum logic [2:0] pwr_state_t, encoded IDLE=0, WARMUP=1, CLEAR=2, NT_COPY=3, NO_OP=4, OP=5, ATS=6, RUN=7.
  - localparam DRUM_BITS_PER_REV = 3132.
- Sub-module rev_counter: load / decrement-on-T0 / terminal flag (rc==1 & T0), parameterized width. The FSM and output decode live in power_sequencer.

## Test plan
- Defaults, T0 every 100 clocks, SW_POWER raised at clock 50 with SW_NT_COPY=0 and SW_ATS=0 → PWR_CLEAR high through 4 T0s plus 2 more; PWR_NO_OP high exactly 200 clocks; PWR_OP high 100 clocks; then PWR_RUN=1 and PWR_STATE=7.
- SW_NT_COPY=1 → PWR_NT high for exactly 100 clocks between CLEAR and NO_OP, with PWR_NO_CLEAR=1 during it.
- SW_ATS=1, ATS_DONE raised 30 clocks into ATS → PWR_ATS falls and PWR_RUN rises on the following edge. With ATS_DONE never raised, RUN is reached after 64 T0s.
- SW_POWER dropped mid-NO_OP, in the same cycle as T0 → next edge: PWR_STATE=0, PWR_CLEAR=1, PWR_NO_OP=0. Re-raising SW_POWER restarts WARMUP with the full count.
- rst asserted asynchronously in RUN (between edges) → outputs reach reset values immediately. After release, the sequence requires SW_POWER high again.
- Randomized T0 spacing ≥2 with assertions: PWR_NO_CLEAR==~PWR_CLEAR; phase outputs are one-hot; every timed phase spans exactly its parameter count of T0 pulses.
